// File: rtl/vga_scan_if.sv
// vga_scan_if: bundles the pixel-source handshake and the video output bus of vga_scan.
//
// Signals
//   blank     source -> scan  force colour to zero for this fetch slot
//   pixel     source -> scan  {r,g,b} returned for an earlier advance
//   advance   scan -> source  pixel fetch request
//   hs, vs    scan -> sink    sync outputs
//   de        scan -> sink    display enable
//   r, g, b   scan -> sink    colour channels, CW bits each
//   newline   scan -> sink    pulse at the first position of each source line
//   newframe  scan -> sink    pulse at position (0,0)
//   line      scan -> sink    current source line index
//
// Modports
//   master  the scan generator
//   slave   the source/sink side (line buffer, DAC, bench)

interface vga_scan_if #(
  parameter int unsigned CW     = 4,
  parameter int unsigned LINE_W = 8
);

  logic              blank;
  logic [3*CW-1:0]   pixel;
  logic              advance;
  logic              hs;
  logic              vs;
  logic              de;
  logic [CW-1:0]     r;
  logic [CW-1:0]     g;
  logic [CW-1:0]     b;
  logic              newline;
  logic              newframe;
  logic [LINE_W-1:0] line;

  modport master (
    input  blank,
    input  pixel,
    output advance,
    output hs,
    output vs,
    output de,
    output r,
    output g,
    output b,
    output newline,
    output newframe,
    output line
  );

  modport slave (
    output blank,
    output pixel,
    input  advance,
    input  hs,
    input  vs,
    input  de,
    input  r,
    input  g,
    input  b,
    input  newline,
    input  newframe,
    input  line
  );

endinterface

// File: rtl/vga_scan.sv
// vga_scan: parametrised raster timing generator and pixel output stage.
//
// Walks a raster of H_TOT x V_TOT positions (sync, back porch, active, front porch in both
// directions), requests pixels from an upstream source ahead of time and presents them,
// replicated 2^HSCALE times horizontally and 2^VSCALE times vertically, on the colour outputs.
//
// Ports
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   bus    vga_scan_if.master: blank/pixel in, advance, hs/vs/de, r/g/b, newline, newframe,
//          line out
//
// All outputs are registered. hc_q/vc_q hold the position the outputs will present after the
// next clock edge, so every output register is a pure function of (hc_q, vc_q) plus the
// source inputs sampled at that edge. After reset the first edge therefore presents (0,0).

module vga_scan #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 30,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 12,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CW       = 4,
  parameter int unsigned HSCALE   = 0,
  parameter int unsigned VSCALE   = 1,
  parameter int unsigned LATENCY  = 0,
  parameter int unsigned LINE_W   = 8
) (
  input logic        clk,
  input logic        rst_n,
  vga_scan_if.master bus
);

  localparam int unsigned H_TOT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int unsigned VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
  // One spare bit so active-end bounds and the fetch look-ahead never overflow.
  localparam int unsigned HX    = HW + 1;
  localparam int unsigned VX    = VW + 1;
  localparam int unsigned PW    = 3 * CW;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
  localparam logic [HX-1:0] H_ACT0   = HX'(H_SYNC + H_BACK);
  localparam logic [HX-1:0] H_ACT1   = HX'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [HX-1:0] H_LOOK   = HX'(LATENCY + 1);
  localparam logic [HX-1:0] H_GMASK  = HX'((1 << HSCALE) - 1);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
  localparam logic [VX-1:0] V_ACT0   = VX'(V_SYNC + V_BACK);
  localparam logic [VX-1:0] V_ACT1   = VX'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [VX-1:0] V_LMASK  = VX'((1 << VSCALE) - 1);

  // Position to be presented after the next edge.
  logic [HW-1:0]     hc_q, hc_d;
  logic [VW-1:0]     vc_q, vc_d;

  // Output registers.
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              de_q, de_d;
  logic              adv_q, adv_d;
  logic              nl_q, nl_d;
  logic              nf_q, nf_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [PW-1:0]     rgb_q, rgb_d;

  // Pixel of the current horizontal group, held across its replicated positions.
  logic [PW-1:0]     pix_q, pix_d;

  logic [HX-1:0]     hc_x, la_x;
  logic [VX-1:0]     vc_x, vy_x;
  logic              h_act, v_act, la_act;
  logic              grp_first, la_first;
  logic              fetch;

  // Position decode.
  always_comb begin
    hc_x      = {1'b0, hc_q};
    vc_x      = {1'b0, vc_q};
    la_x      = hc_x + H_LOOK;
    vy_x      = vc_x - V_ACT0;

    h_act     = (hc_x >= H_ACT0) && (hc_x < H_ACT1);
    v_act     = (vc_x >= V_ACT0) && (vc_x < V_ACT1);
    // Look-ahead stays on the same line: the active region ends before H_TOT, so any
    // look-ahead position past the line end simply decodes as inactive.
    la_act    = (la_x >= H_ACT0) && (la_x < H_ACT1);

    grp_first = ((hc_x - H_ACT0) & H_GMASK) == '0;
    la_first  = ((la_x - H_ACT0) & H_GMASK) == '0;

    // The edge that loads a group-first active position is exactly the edge that ends
    // cycle n+LATENCY of the matching advance, so the source pixel is valid right now.
    fetch     = h_act && v_act && grp_first;
  end

  // Raster counters.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + VW'(1);
    end else begin
      hc_d = hc_q + HW'(1);
    end
  end

  // Next values of the registered outputs for position (hc_q, vc_q).
  always_comb begin
    hs_d   = (hc_q < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    vs_d   = (vc_q < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    de_d   = h_act && v_act;
    adv_d  = la_act && v_act && la_first;
    nf_d   = (hc_q == '0) && (vc_q == '0);
    nl_d   = (hc_q == '0) && v_act && ((vy_x & V_LMASK) == '0);

    line_d = line_q;
    if (hc_q == '0) begin
      line_d = v_act ? LINE_W'(vy_x >> VSCALE) : '0;
    end

    pix_d  = fetch ? bus.pixel : pix_q;
    // blank is taken in the cycle the pixel would be sampled; it never disturbs fetches.
    rgb_d  = (de_d && !bus.blank) ? pix_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q   <= '0;
      vc_q   <= '0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      de_q   <= 1'b0;
      adv_q  <= 1'b0;
      nl_q   <= 1'b0;
      nf_q   <= 1'b0;
      line_q <= '0;
      rgb_q  <= '0;
      pix_q  <= '0;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      adv_q  <= adv_d;
      nl_q   <= nl_d;
      nf_q   <= nf_d;
      line_q <= line_d;
      rgb_q  <= rgb_d;
      pix_q  <= pix_d;
    end
  end

  assign bus.hs       = hs_q;
  assign bus.vs       = vs_q;
  assign bus.de       = de_q;
  assign bus.advance  = adv_q;
  assign bus.newline  = nl_q;
  assign bus.newframe = nf_q;
  assign bus.line     = line_q;
  assign bus.r        = rgb_q[3*CW-1:2*CW];
  assign bus.g        = rgb_q[2*CW-1:CW];
  assign bus.b        = rgb_q[CW-1:0];

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: directed bench for vga_scan using two small rasters.
//   dut_a: H 8/4/16/4, V 1/1/4/1, SYNC_POL=1, HSCALE=0, VSCALE=1, LATENCY=0
//          H_TOT=32, V_TOT=7, HA0=12, VA0=2; pixel driven = cycle index.
//   dut_b: H 4/4/16/4, V 1/1/4/1, SYNC_POL=0, HSCALE=1, VSCALE=0, LATENCY=2
//          H_TOT=28, V_TOT=7, HA0=8,  VA0=2; source returns an incrementing count.
// Cycle k=0 is the cycle after the first edge following reset release.

module tb_vga_scan;

  localparam int NREC = 400;

  logic clk;
  logic rst_n;

  vga_scan_if #(.CW(4), .LINE_W(8)) bus_a ();
  vga_scan_if #(.CW(4), .LINE_W(8)) bus_b ();

  vga_scan #(
    .H_SYNC(8), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
    .SYNC_POL(1'b1), .CW(4), .HSCALE(0), .VSCALE(1), .LATENCY(0), .LINE_W(8)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  vga_scan #(
    .H_SYNC(4), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
    .SYNC_POL(1'b0), .CW(4), .HSCALE(1), .VSCALE(0), .LATENCY(2), .LINE_W(8)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit          a_hs [NREC];
  bit          a_vs [NREC];
  bit          a_de [NREC];
  bit          a_adv[NREC];
  bit          a_nl [NREC];
  bit          a_nf [NREC];
  int unsigned a_line[NREC];
  int unsigned a_rgb [NREC];

  bit          b_hs [NREC];
  bit          b_vs [NREC];
  bit          b_de [NREC];
  bit          b_adv[NREC];
  bit          b_nl [NREC];
  bit          b_nf [NREC];
  int unsigned b_line[NREC];
  int unsigned b_rgb [NREC];

  bit blank_en;
  int src_cnt;

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Records n cycles of both DUTs at the falling edge and drives the sources for each cycle.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a_hs[k]   = bus_a.hs;
      a_vs[k]   = bus_a.vs;
      a_de[k]   = bus_a.de;
      a_adv[k]  = bus_a.advance;
      a_nl[k]   = bus_a.newline;
      a_nf[k]   = bus_a.newframe;
      a_line[k] = 32'(bus_a.line);
      a_rgb[k]  = 32'({bus_a.r, bus_a.g, bus_a.b});
      b_hs[k]   = bus_b.hs;
      b_vs[k]   = bus_b.vs;
      b_de[k]   = bus_b.de;
      b_adv[k]  = bus_b.advance;
      b_nl[k]   = bus_b.newline;
      b_nf[k]   = bus_b.newframe;
      b_line[k] = 32'(bus_b.line);
      b_rgb[k]  = 32'({bus_b.r, bus_b.g, bus_b.b});

      bus_a.pixel = 12'(k);
      bus_a.blank = blank_en && (k >= 110) && (k <= 119);
      // LATENCY=2: answer the advance seen two cycles ago.
      if (k >= 2 && b_adv[k-2]) begin
        bus_b.pixel = 12'(src_cnt);
        src_cnt++;
      end
    end
  endtask

  initial begin
    int c_hs, c_vs, c_de, c_nf, c_nl, c_adv, c_rgb, c_line;

    rst_n       = 1'b0;
    bus_a.pixel = '0;
    bus_a.blank = 1'b0;
    bus_b.pixel = '0;
    bus_b.blank = 1'b0;
    blank_en    = 1'b1;
    src_cnt     = 0;

    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_a_hs",   bus_a.hs, 0);
    check("rst_a_vs",   bus_a.vs, 0);
    check("rst_a_de",   bus_a.de, 0);
    check("rst_a_adv",  bus_a.advance, 0);
    check("rst_a_nf",   bus_a.newframe, 0);
    check("rst_a_nl",   bus_a.newline, 0);
    check("rst_a_line", 32'(bus_a.line), 0);
    check("rst_a_rgb",  32'({bus_a.r, bus_a.g, bus_a.b}), 0);
    check("rst_b_hs",   bus_b.hs, 1);
    check("rst_b_vs",   bus_b.vs, 1);

    rst_n = 1'b1;
    run_cycles(365);

    // dut_a: first position and sync edges.
    check("a_nf_k0",  a_nf[0], 1);
    check("a_hs_k0",  a_hs[0], 1);
    check("a_vs_k0",  a_vs[0], 1);
    check("a_de_k0",  a_de[0], 0);
    check("a_nf_k1",  a_nf[1], 0);
    check("a_hs_k7",  a_hs[7], 1);
    check("a_hs_k8",  a_hs[8], 0);
    check("a_vs_k31", a_vs[31], 1);
    check("a_vs_k32", a_vs[32], 0);
    check("a_hs_k32", a_hs[32], 1);
    // Active window and one-cycle fetch lead.
    check("a_de_k75",  a_de[75], 0);
    check("a_de_k76",  a_de[76], 1);
    check("a_de_k91",  a_de[91], 1);
    check("a_de_k92",  a_de[92], 0);
    check("a_adv_k74", a_adv[74], 0);
    check("a_adv_k75", a_adv[75], 1);
    check("a_adv_k90", a_adv[90], 1);
    check("a_adv_k91", a_adv[91], 0);
    check("a_rgb_k76", a_rgb[76], 75);
    check("a_rgb_k91", a_rgb[91], 90);
    check("a_rgb_k92", a_rgb[92], 0);
    // Line markers with VSCALE=1.
    check("a_nl_k64",    a_nl[64], 1);
    check("a_nl_k96",    a_nl[96], 0);
    check("a_nl_k128",   a_nl[128], 1);
    check("a_line_k127", a_line[127], 0);
    check("a_line_k128", a_line[128], 1);
    check("a_line_k191", a_line[191], 1);
    check("a_line_k192", a_line[192], 0);
    check("a_nf_k224",   a_nf[224], 1);
    // blank high in cycles 110..119 zeroes positions 111..120.
    check("a_rgb_k110", a_rgb[110], 109);
    check("a_rgb_k111", a_rgb[111], 0);
    check("a_rgb_k120", a_rgb[120], 0);
    check("a_rgb_k121", a_rgb[121], 120);

    c_hs = 0; c_vs = 0; c_de = 0; c_nf = 0; c_nl = 0; c_adv = 0; c_rgb = 0;
    for (int k = 0; k < 224; k++) begin
      c_hs  += int'(a_hs[k]);
      c_vs  += int'(a_vs[k]);
      c_de  += int'(a_de[k]);
      c_nf  += int'(a_nf[k]);
      c_nl  += int'(a_nl[k]);
      c_adv += int'(a_adv[k]);
      if (a_rgb[k] != 0) c_rgb++;
    end
    check("a_cnt_hs",  c_hs, 56);
    check("a_cnt_vs",  c_vs, 32);
    check("a_cnt_de",  c_de, 64);
    check("a_cnt_nf",  c_nf, 1);
    check("a_cnt_nl",  c_nl, 2);
    check("a_cnt_adv", c_adv, 64);
    check("a_cnt_rgb", c_rgb, 54);
    c_adv = 0;
    for (int k = 96; k < 128; k++) c_adv += int'(a_adv[k]);
    check("a_adv_blank_line", c_adv, 16);

    // dut_b: syncs, HSCALE=1 fetch pattern, LATENCY=2 pixel path.
    check("b_hs_k0",   b_hs[0], 0);
    check("b_hs_k3",   b_hs[3], 0);
    check("b_hs_k4",   b_hs[4], 1);
    check("b_vs_k0",   b_vs[0], 0);
    check("b_vs_k28",  b_vs[28], 1);
    check("b_adv_k60", b_adv[60], 0);
    check("b_adv_k61", b_adv[61], 1);
    check("b_adv_k62", b_adv[62], 0);
    check("b_adv_k63", b_adv[63], 1);
    check("b_adv_k75", b_adv[75], 1);
    check("b_adv_k77", b_adv[77], 0);
    check("b_de_k63",  b_de[63], 0);
    check("b_de_k64",  b_de[64], 1);
    for (int k = 64; k < 80; k++) check($sformatf("b_rgb_k%0d", k), b_rgb[k], (k - 64) / 2);
    for (int k = 92; k < 108; k++) check($sformatf("b_rgb_k%0d", k), b_rgb[k], 8 + (k - 92) / 2);
    check("b_rgb_k80",   b_rgb[80], 0);
    check("b_line_k140", b_line[140], 3);
    check("b_line_k168", b_line[168], 0);
    check("b_nf_k196",   b_nf[196], 1);

    c_hs = 0; c_de = 0; c_nl = 0; c_adv = 0; c_line = 0;
    for (int k = 0; k < 196; k++) begin
      c_hs  += int'(b_hs[k]);
      c_de  += int'(b_de[k]);
      c_nl  += int'(b_nl[k]);
      c_adv += int'(b_adv[k]);
    end
    for (int k = 56; k < 84; k++) c_line += int'(b_adv[k]);
    check("b_cnt_hs",       c_hs, 168);
    check("b_cnt_de",       c_de, 64);
    check("b_cnt_nl",       c_nl, 4);
    check("b_cnt_adv",      c_adv, 32);
    check("b_adv_per_line", c_line, 8);

    // Mid-active-line reset on dut_a (k=364 is vc=4, hc=12 of the second frame).
    check("a_de_k364",   a_de[364], 1);
    check("a_line_k364", a_line[364], 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a_hs",   bus_a.hs, 0);
    check("arst_a_vs",   bus_a.vs, 0);
    check("arst_a_de",   bus_a.de, 0);
    check("arst_a_adv",  bus_a.advance, 0);
    check("arst_a_line", 32'(bus_a.line), 0);
    check("arst_a_rgb",  32'({bus_a.r, bus_a.g, bus_a.b}), 0);
    check("arst_b_hs",   bus_b.hs, 1);

    @(negedge clk);
    @(negedge clk);
    blank_en = 1'b0;
    src_cnt  = 0;
    rst_n    = 1'b1;
    run_cycles(225);

    check("r2_a_nf_k0",     a_nf[0], 1);
    check("r2_a_hs_k0",     a_hs[0], 1);
    check("r2_a_de_k76",    a_de[76], 1);
    check("r2_a_rgb_k76",   a_rgb[76], 75);
    check("r2_a_rgb_k111",  a_rgb[111], 110);
    check("r2_a_line_k128", a_line[128], 1);
    check("r2_a_nf_k224",   a_nf[224], 1);
    c_de = 0; c_nf = 0; c_nl = 0;
    for (int k = 0; k < 224; k++) begin
      c_de += int'(a_de[k]);
      c_nf += int'(a_nf[k]);
      c_nl += int'(a_nl[k]);
    end
    check("r2_a_cnt_de", c_de, 64);
    check("r2_a_cnt_nf", c_nf, 1);
    check("r2_a_cnt_nl", c_nl, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_scan.md
# vga_scan

Parametrised raster timing generator and pixel output stage for the VGA path. It generalises the fixed 640x480 scan generator: all horizontal and vertical porch and sync widths, sync polarity and colour depth are parameters. It adds power-of-two pixel and line replication, a configurable pixel-source fetch latency, frame and line markers, and an asynchronous reset. It sits between the line-buffer / pixel generator (upstream) and the DAC pins (downstream).

## Interface
- H_SYNC, 96: hsync width, pixels
- H_BACK, 48: horizontal back porch, pixels
- H_ACTIVE, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, pixels
- V_SYNC, 2: vsync width, lines
- V_BACK, 30: vertical back porch, lines
- V_ACTIVE, 480: visible lines
- V_FRONT, 12: vertical front porch, lines
- SYNC_POL, 0: asserted level of hs/vs
- CW, 4: bits per colour channel
- HSCALE, 0: each source pixel is shown 2^HSCALE times
- VSCALE, 1: each source line is shown 2^VSCALE times
- LATENCY, 0: cycles from advance to pixel valid; requires LATENCY+1 <= H_SYNC+H_BACK
- LINE_W, 8: width of line output
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- blank  in  1  force rgb to zero; timing and advance are unaffected
- pixel  in  3*CW  {r,g,b} from the source
- hs, vs  out  1  syncs
- de  out  1  display enable (active region)
- r, g, b  out  CW each  colour, zero outside the active region
- advance  out  1  pixel fetch request
- newline  out  1  one-cycle pulse at the start of each new source line
- newframe  out  1  one-cycle pulse at the start of each frame
- line  out  LINE_W  current source line index

## Operation
- H_TOT = sum of the H_* parameters; V_TOT = sum of the V_* parameters. Counters hc 0..H_TOT-1 and vc 0..V_TOT-1. vc increments when hc wraps, and vc wraps to 0 after V_TOT-1.
- Order within a line or frame: sync, back porch, active, front porch. HA0 = H_SYNC+H_BACK; VA0 = V_SYNC+V_BACK.
- Each cycle n presents a position P(n) = (hc, vc). All outputs are registered and aligned to P(n).
  - hs = SYNC_POL when hc < H_SYNC, otherwise the inverse.
  - vs = SYNC_POL when vc < V_SYNC, otherwise the inverse.
  - de = 1 when HA0 <= hc < HA0+H_ACTIVE and VA0 <= vc < VA0+V_ACTIVE.
- Horizontal groups: active pixel x = hc-HA0. x is group-first when x mod 2^HSCALE == 0.
- advance = 1 in cycle n iff position (hc+LATENCY+1, vc) is active and group-first. The source must drive pixel valid in cycle n+LATENCY. The block registers it at the end of that cycle, so the pixel appears on rgb in cycle n+LATENCY+1 and is held for the 2^HSCALE positions of its group.
- rgb = 0 when de=0 or blank=1. Otherwise rgb is the held group pixel. blank is sampled in the same cycle as pixel. A blanked cycle still consumes its fetch slot.
- Source line s = (vc-VA0) >> VSCALE. line = s[LINE_W-1:0] for active vc, otherwise 0. line updates only at hc=0 positions.
- newline = 1 at position hc=0 when vc is active and (vc-VA0) mod 2^VSCALE == 0. Exactly V_ACTIVE>>VSCALE pulses per frame.
- newframe = 1 at position (0,0) only.

## Timing
- Reset (async assert, whatever the counter state):
  - hc = vc = 0.
  - hs = vs = !SYNC_POL; de, advance, newline and newframe are 0; rgb = 0; line = 0.
  - Reset mid-frame abandons the frame. No partial pulses occur after deassertion.
- First rising edge after deassertion: outputs present position (0,0). newframe=1; hs and vs are asserted.
- Line period is H_TOT cycles; frame period is H_TOT*V_TOT cycles.
- advance leads rgb by exactly LATENCY+1 cycles, and never crosses a line boundary.
- Wrap (H_TOT-1, V_TOT-1) → (0,0): newframe pulses the next cycle; the line output remains 0 through vertical blanking.
- HSCALE=0: advance is high for H_ACTIVE consecutive cycles per active line. Larger HSCALE: one pulse every 2^HSCALE cycles.

## Test plan
- Defaults, LATENCY=0 → hs low for 96 of every 800 cycles; vs low for 1600 cycles of every 419200; 307200 de cycles per frame; newframe once per frame.
- Defaults, VSCALE=1 → 240 newline pulses per frame; line steps 0,1,…,239, each value held for 1600 cycles.
- HSCALE=1, LATENCY=2, source returns an incrementing count per advance → 320 advance pulses per line; rgb shows 0,0,1,1,…,319,319 across de; the first rgb value appears 3 cycles after the first advance.
- SYNC_POL=1, custom 8/4/16/4 H and 1/1/4/1 V → hs high 8 of 32 cycles; vs high 32 of 224 cycles; de 16x4.
- blank high for 10 mid-line cycles → rgb=0 for those positions; advance count per line is unchanged; the following pixels resume in sequence.
- rst_n pulsed low mid-active-line → outputs take reset values immediately; after release, newframe fires on the first edge and the full frame sequence repeats.
